reloj_bcd: RTL

Time-of-day counter for the digital clock. It divides the system clock down to a 1 Hz tick and keeps hours, minutes and seconds as six BCD digits in 24-hour format. It also supports a manual set mode. Each 4-bit digit output drives one 7-segment decoder instance directly, so this block sits immediately upstream of the segment decoders.

---
 rtl/reloj_pkg.sv | 35 +++
 rtl/divisor_frecuencia.sv | 33 +++
 rtl/reloj_bcd.sv | 109 ++++++++++
 3 files changed

// File: rtl/reloj_pkg.sv
// Shared types, digit limits and BCD increment helpers for the time-of-day counter.
package reloj_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t MAX_U         = 4'd9;
   localparam bcd_t MAX_SEG_D     = 4'd5;
   localparam bcd_t MAX_MIN_D     = 4'd5;
   localparam bcd_t MAX_HORA_D    = 4'd2;
   localparam bcd_t MAX_HORA_U_23 = 4'd3;

   // Returns {carry, next}; wraps to 0 and raises carry when the digit is at its limit.
   function automatic logic [4:0] inc_dig(input bcd_t v, input bcd_t max);
      logic [4:0] r;
      if (v == max) begin
         r = {1'b1, 4'd0};
      end else begin
         r = {1'b0, v + 4'd1};
      end
      return r;
   endfunction

   function automatic logic [7:0] inc_hora(input bcd_t d, input bcd_t u);
      logic [7:0] r;
      if ((d == MAX_HORA_D) && (u == MAX_HORA_U_23)) begin
         r = 8'h00;
      end else if (u == MAX_U) begin
         r = {d + 4'd1, 4'd0};
      end else begin
         r = {d, u + 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/divisor_frecuencia.sv
// Prescaler dividing the system clock by exactly CLK_HZ; tick strobes in the cycle the count sits at CLK_HZ-1.
module divisor_frecuencia #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int             W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [W-1:0]   LAST = W'(CLK_HZ - 1);
   localparam logic [W-1:0]   ONE  = W'(1);

   logic [W-1:0] r_cnt;

   // Free-running 0..CLK_HZ-1 count, parked at zero while clr is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + ONE;
      end
   end

   // Wrap strobe; the consumer registers it, so it never reaches a port directly.
   assign tick = (r_cnt == LAST) && !clr;

endmodule

// File: rtl/reloj_bcd.sv
// 24-hour hh:mm:ss BCD time-of-day counter with a manual set mode.
module reloj_bcd
   import reloj_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ajuste,
   input  logic       inc_minutos,
   input  logic       inc_horas,
   output logic [3:0] hora_d,
   output logic [3:0] hora_u,
   output logic [3:0] min_d,
   output logic [3:0] min_u,
   output logic [3:0] seg_d,
   output logic [3:0] seg_u,
   output logic       tick_1hz
);

   logic w_tick;
   bcd_t r_hora_d, r_hora_u, r_min_d, r_min_u, r_seg_d, r_seg_u;
   bcd_t w_hora_d, w_hora_u, w_min_d, w_min_u, w_seg_d, w_seg_u;
   logic r_tick;
   logic [4:0] w_su, w_sd, w_mu, w_md;
   logic [7:0] w_h;
   logic w_c0, w_c1, w_c2, w_c3;

   divisor_frecuencia #(.CLK_HZ(CLK_HZ)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (ajuste),
      .tick  (w_tick)
   );

   // Next-state digits: set-mode increments take priority over the run-mode carry chain.
   always_comb begin
      w_hora_d = r_hora_d;
      w_hora_u = r_hora_u;
      w_min_d  = r_min_d;
      w_min_u  = r_min_u;
      w_seg_d  = r_seg_d;
      w_seg_u  = r_seg_u;
      w_su = inc_dig(r_seg_u, MAX_U);
      w_sd = inc_dig(r_seg_d, MAX_SEG_D);
      w_mu = inc_dig(r_min_u, MAX_U);
      w_md = inc_dig(r_min_d, MAX_MIN_D);
      w_h  = inc_hora(r_hora_d, r_hora_u);
      w_c0 = w_su[4];
      w_c1 = w_c0 & w_sd[4];
      w_c2 = w_c1 & w_mu[4];
      w_c3 = w_c2 & w_md[4];
      if (ajuste) begin
         w_seg_d = 4'd0;
         w_seg_u = 4'd0;
         // Minutes wrap 59->00 here without touching the hours.
         if (inc_minutos) begin
            w_min_u = w_mu[3:0];
            w_min_d = w_mu[4] ? w_md[3:0] : r_min_d;
         end else begin
            w_min_u = r_min_u;
            w_min_d = r_min_d;
         end
         if (inc_horas) begin
            {w_hora_d, w_hora_u} = w_h;
         end else begin
            {w_hora_d, w_hora_u} = {r_hora_d, r_hora_u};
         end
      end else if (w_tick) begin
         w_seg_u = w_su[3:0];
         w_seg_d = w_c0 ? w_sd[3:0] : r_seg_d;
         w_min_u = w_c1 ? w_mu[3:0] : r_min_u;
         w_min_d = w_c2 ? w_md[3:0] : r_min_d;
         {w_hora_d, w_hora_u} = w_c3 ? w_h : {r_hora_d, r_hora_u};
      end else begin
         w_seg_u = r_seg_u;
      end
   end

   // Digit and tick registers; tick and new digits appear together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hora_d <= 4'd0;
         r_hora_u <= 4'd0;
         r_min_d  <= 4'd0;
         r_min_u  <= 4'd0;
         r_seg_d  <= 4'd0;
         r_seg_u  <= 4'd0;
         r_tick   <= 1'b0;
      end else begin
         r_hora_d <= w_hora_d;
         r_hora_u <= w_hora_u;
         r_min_d  <= w_min_d;
         r_min_u  <= w_min_u;
         r_seg_d  <= w_seg_d;
         r_seg_u  <= w_seg_u;
         r_tick   <= w_tick;
      end
   end

   assign hora_d   = r_hora_d;
   assign hora_u   = r_hora_u;
   assign min_d    = r_min_d;
   assign min_u    = r_min_u;
   assign seg_d    = r_seg_d;
   assign seg_u    = r_seg_u;
   assign tick_1hz = r_tick;

endmodule
